// File: rtl/data_arrays_port_ctrl.sv
// Single-port SRAM front end: read/write arbitration plus a 2-entry read-response FIFO.
// Define SRAM_ARB_RR_EN for round-robin arbitration; default is fixed write priority.
module data_arrays_port_ctrl #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 256,
    parameter int MASK_W = 32
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_rd_req_valid,
    output logic              o_rd_req_ready,
    input  logic [ADDR_W-1:0] i_rd_req_addr,
    input  logic              i_wr_req_valid,
    output logic              o_wr_req_ready,
    input  logic [ADDR_W-1:0] i_wr_req_addr,
    input  logic [DATA_W-1:0] i_wr_req_data,
    input  logic [MASK_W-1:0] i_wr_req_mask,
    output logic              o_rd_resp_valid,
    input  logic              i_rd_resp_ready,
    output logic [DATA_W-1:0] o_rd_resp_data,
    output logic [ADDR_W-1:0] o_RW0_addr,
    output logic              o_RW0_en,
    output logic              o_RW0_wmode,
    output logic [MASK_W-1:0] o_RW0_wmask,
    output logic [DATA_W-1:0] o_RW0_wdata,
    input  logic [DATA_W-1:0] i_RW0_rdata
);

    logic [1:0]        r_count;
    logic              r_inflight;
    logic              r_rd_ptr;
    logic              r_wr_ptr;
    logic [DATA_W-1:0] r_mem [2];

    logic              w_pop;
    logic              w_push;
    logic [2:0]        w_level;
    logic              w_space;
    logic              w_wr_pri;
    logic              w_rd_fire;
    logic              w_wr_fire;

    assign w_pop   = (r_count != 2'd0) && i_rd_resp_ready && !i_reset;
    assign w_push  = r_inflight && !i_reset;
    // A same-cycle pop frees a slot so reads can stream at one per cycle
    assign w_level = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_space = (w_level < 3'd2);

`ifdef SRAM_ARB_RR_EN
    logic r_last_rd;

    assign w_wr_pri = r_last_rd;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_last_rd <= 1'b0;
        end else if (w_rd_fire) begin
            r_last_rd <= 1'b1;
        end else if (w_wr_fire) begin
            r_last_rd <= 1'b0;
        end
    end
`else
    assign w_wr_pri = 1'b1;
`endif

    assign o_rd_req_ready = !i_reset && w_space && !(i_wr_req_valid && w_wr_pri);
    assign o_wr_req_ready = !i_reset && !(i_rd_req_valid && w_space && !w_wr_pri);
    assign w_rd_fire      = i_rd_req_valid && o_rd_req_ready;
    assign w_wr_fire      = i_wr_req_valid && o_wr_req_ready;

    always_comb begin
        o_RW0_en    = 1'b0;
        o_RW0_wmode = 1'b0;
        o_RW0_addr  = '0;
        o_RW0_wmask = '0;
        o_RW0_wdata = '0;
        if (w_wr_fire) begin
            o_RW0_en    = 1'b1;
            o_RW0_wmode = 1'b1;
            o_RW0_addr  = i_wr_req_addr;
            o_RW0_wmask = i_wr_req_mask;
            o_RW0_wdata = i_wr_req_data;
        end else if (w_rd_fire) begin
            o_RW0_en    = 1'b1;
            o_RW0_addr  = i_rd_req_addr;
        end
    end

    always_comb begin
        o_rd_resp_valid = !i_reset && (r_count != 2'd0);
        o_rd_resp_data  = '0;
        if (o_rd_resp_valid) begin
            o_rd_resp_data = r_mem[r_rd_ptr];
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
        end else begin
            r_inflight <= w_rd_fire;
            if (w_push) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 2'd1;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is visible
    always_ff @(posedge i_clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_RW0_rdata;
        end
    end

endmodule
